// File: rtl/gpreg_wb_queue_pkg.sv
// Shared definitions for the GPR writeback queue: id/data widths, special
// register ids and the queue slot layout.
package gpreg_wb_queue_pkg;

  localparam int ID_W   = 7;
  localparam int DATA_W = 64;

  localparam logic [ID_W-1:0] REG_ZZR     = 7'h5F;
  localparam logic [ID_W-1:0] REG_SPEC_LO = 7'h58;
  localparam logic [ID_W-1:0] REG_SPEC_HI = 7'h5B;

  typedef struct packed {
    logic              qw;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } wbEntry_t;

  // Ids that have no backing storage in the bank and are silently dropped.
  function automatic logic isDiscardId(input logic [ID_W-1:0] id);
    return ((id >= REG_SPEC_LO) && (id <= REG_SPEC_HI)) || (id == REG_ZZR);
  endfunction

endpackage

// File: rtl/gpreg_wb_lookup.sv
// One read-after-write lookup port: picks the youngest pending write that
// overlaps the looked-up id and decides forward versus hazard.
module gpreg_wb_lookup
  import gpreg_wb_queue_pkg::*;
#(
  parameter int NCAND = 5
) (
  input  logic [NCAND-1:0]           candVld,
  input  wbEntry_t [NCAND-1:0]       cand,
  input  logic [ID_W-1:0]            idReg,
  output logic                       fwdHit,
  output logic [DATA_W-1:0]          fwdData,
  output logic                       hazard
);

  logic     anyHit;
  wbEntry_t sel;

  always_comb begin
    anyHit  = 1'b0;
    sel     = '0;
    fwdHit  = 1'b0;
    fwdData = '0;
    hazard  = 1'b0;
    // Candidates are ordered oldest to youngest, so the last match wins.
    for (int i = 0; i < NCAND; i++) begin
      if (candVld[i] && (cand[i].id[5:0] == idReg[5:0])) begin
        anyHit = 1'b1;
        sel    = cand[i];
      end
    end
    if (anyHit && (idReg != REG_ZZR)) begin
      if (sel.qw && (sel.id == idReg) && !idReg[6]) begin
        fwdHit  = 1'b1;
        fwdData = sel.data;
      end else if (!sel.qw && (sel.id == idReg) && idReg[6] && (idReg[5:4] != 2'b01)) begin
        fwdHit  = 1'b1;
        fwdData = {32'h0, sel.data[31:0]};
      end else begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpreg_wb_queue.sv
// In-order writeback FIFO in front of the GPR bank write port, draining one
// write per cycle, with three read-after-write forward/hazard lookups.
module gpreg_wb_queue
  import gpreg_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aluWr,
  input  logic              aluQw,
  input  logic [ID_W-1:0]   aluReg,
  input  logic [DATA_W-1:0] aluData,
  input  logic              memWr,
  input  logic              memQw,
  input  logic [ID_W-1:0]   memReg,
  input  logic [DATA_W-1:0] memData,
  output logic              wbStall,
  output logic              ovfErr,
  output logic              isWrD,
  output logic              isQwD,
  output logic [ID_W-1:0]   idRegD,
  output logic [DATA_W-1:0] dataD,
  input  logic [ID_W-1:0]   idReg1,
  input  logic [ID_W-1:0]   idReg2,
  input  logic [ID_W-1:0]   idReg3,
  output logic              fwdHit1,
  output logic              fwdHit2,
  output logic              fwdHit3,
  output logic [DATA_W-1:0] fwdData1,
  output logic [DATA_W-1:0] fwdData2,
  output logic [DATA_W-1:0] fwdData3,
  output logic              hazard1,
  output logic              hazard2,
  output logic              hazard3
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbEntry_t         fifo [DEPTH];
  logic [PTR_W-1:0] rdPtr, wrPtr, aluSlot;
  logic [CNT_W-1:0] count, freeSlots;
  logic [1:0]       nEnq;
  logic             deq, memEn, aluEn, memAcc, aluAcc, drop;
  wbEntry_t         memEnt, aluEnt;
  logic [DEPTH:0]   candVld;
  wbEntry_t [DEPTH:0] cand;

  assign memEnt = '{qw: memQw, id: memReg, data: memData};
  assign aluEnt = '{qw: aluQw, id: aluReg, data: aluData};

  // Slot accounting counts the head leaving this cycle as free; MEM claims first.
  always_comb begin
    deq       = (count != '0);
    freeSlots = CNT_W'(DEPTH) - count + CNT_W'(deq);
    memEn     = memWr && !isDiscardId(memReg);
    aluEn     = aluWr && !isDiscardId(aluReg);
    memAcc    = memEn && (freeSlots != '0);
    aluAcc    = aluEn && (freeSlots > CNT_W'(memAcc));
    drop      = (memEn && !memAcc) || (aluEn && !aluAcc);
    nEnq      = {1'b0, memAcc} + {1'b0, aluAcc};
    aluSlot   = memAcc ? (wrPtr + PTR_W'(1)) : wrPtr;
  end

  assign wbStall = (count >= CNT_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (memAcc) fifo[wrPtr] <= memEnt;
    if (aluAcc) fifo[aluSlot] <= aluEnt;
  end

  // Output stage: registered bank write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr  <= '0;
      wrPtr  <= '0;
      count  <= '0;
      isWrD  <= 1'b0;
      isQwD  <= 1'b0;
      idRegD <= '0;
      dataD  <= '0;
      ovfErr <= 1'b0;
    end else begin
      isWrD <= deq;
      if (deq) begin
        rdPtr  <= rdPtr + PTR_W'(1);
        isQwD  <= fifo[rdPtr].qw;
        idRegD <= fifo[rdPtr].id;
        dataD  <= fifo[rdPtr].data;
      end
      wrPtr <= wrPtr + PTR_W'(nEnq);
      count <= count + CNT_W'(nEnq) - CNT_W'(deq);
      if (drop) ovfErr <= 1'b1;
    end
  end

  // Output stage is the oldest candidate, then FIFO entries head to tail.
  always_comb begin
    candVld[0] = isWrD;
    cand[0]    = '{qw: isQwD, id: idRegD, data: dataD};
    for (int i = 0; i < DEPTH; i++) begin
      candVld[i+1] = (CNT_W'(i) < count);
      cand[i+1]    = fifo[rdPtr + PTR_W'(i)];
    end
  end

  gpreg_wb_lookup #(.NCAND(DEPTH + 1)) uLookup1 (
    .candVld(candVld), .cand(cand), .idReg(idReg1),
    .fwdHit(fwdHit1), .fwdData(fwdData1), .hazard(hazard1)
  );

  gpreg_wb_lookup #(.NCAND(DEPTH + 1)) uLookup2 (
    .candVld(candVld), .cand(cand), .idReg(idReg2),
    .fwdHit(fwdHit2), .fwdData(fwdData2), .hazard(hazard2)
  );

  gpreg_wb_lookup #(.NCAND(DEPTH + 1)) uLookup3 (
    .candVld(candVld), .cand(cand), .idReg(idReg3),
    .fwdHit(fwdHit3), .fwdData(fwdData3), .hazard(hazard3)
  );

endmodule

// File: tb/tb_gpreg_wb_queue.sv
// Scoreboard bench for gpreg_wb_queue: expected bank writes are queued at
// stimulus time and matched by a monitor whenever isWrD is presented.
module tb_gpreg_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aluWr, aluQw, memWr, memQw;
  logic [6:0]  aluReg, memReg;
  logic [63:0] aluData, memData;
  logic        wbStall, ovfErr, isWrD, isQwD;
  logic [6:0]  idRegD;
  logic [63:0] dataD;
  logic [6:0]  idReg1, idReg2, idReg3;
  logic        fwdHit1, fwdHit2, fwdHit3, hazard1, hazard2, hazard3;
  logic [63:0] fwdData1, fwdData2, fwdData3;

  int checks = 0;
  int errors = 0;
  logic [71:0] expQ [$];

  gpreg_wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .aluWr(aluWr), .aluQw(aluQw), .aluReg(aluReg), .aluData(aluData),
    .memWr(memWr), .memQw(memQw), .memReg(memReg), .memData(memData),
    .wbStall(wbStall), .ovfErr(ovfErr),
    .isWrD(isWrD), .isQwD(isQwD), .idRegD(idRegD), .dataD(dataD),
    .idReg1(idReg1), .idReg2(idReg2), .idReg3(idReg3),
    .fwdHit1(fwdHit1), .fwdHit2(fwdHit2), .fwdHit3(fwdHit3),
    .fwdData1(fwdData1), .fwdData2(fwdData2), .fwdData3(fwdData3),
    .hazard1(hazard1), .hazard2(hazard2), .hazard3(hazard3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] ent(input logic qw, input logic [6:0] id, input logic [63:0] d);
    return {qw, id, d};
  endfunction

  task automatic idle();
    aluWr = 0; aluQw = 0; aluReg = '0; aluData = '0;
    memWr = 0; memQw = 0; memReg = '0; memData = '0;
  endtask

  task automatic setMem(input logic qw, input logic [6:0] id, input logic [63:0] d);
    memWr = 1; memQw = qw; memReg = id; memData = d;
  endtask

  task automatic setAlu(input logic qw, input logic [6:0] id, input logic [63:0] d);
    aluWr = 1; aluQw = qw; aluReg = id; aluData = d;
  endtask

  // Monitor: every presented bank write must match the oldest expected one.
  always @(negedge clk) begin
    logic [71:0] e;
    if (rst_n && isWrD) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected actual=%h required=none", {isQwD, idRegD, dataD});
      end else begin
        e = expQ.pop_front();
        if ({isQwD, idRegD, dataD} !== e) begin
          errors++;
          $display("FAIL wr_match actual=%h required=%h", {isQwD, idRegD, dataD}, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0;
    idle();
    idReg1 = 7'h00; idReg2 = 7'h00; idReg3 = 7'h00;
    repeat (2) @(negedge clk);
    chk("rst_isWrD", isWrD, 0);
    chk("rst_isQwD", isQwD, 0);
    chk("rst_idRegD", idRegD, 0);
    chk("rst_dataD", dataD, 0);
    chk("rst_ovfErr", ovfErr, 0);
    chk("rst_wbStall", wbStall, 0);
    chk("rst_fwdHit1", fwdHit1, 0);
    chk("rst_hazard1", hazard1, 0);
    rst_n = 1;
    @(negedge clk);

    // Single ALU qw write R3
    setAlu(1, 7'h03, 64'h1122_3344_5566_7788);
    expQ.push_back(ent(1, 7'h03, 64'h1122_3344_5566_7788));
    @(negedge clk); idle();
    chk("t1_lat_isWrD", isWrD, 0);
    @(negedge clk);
    chk("t1_isWrD", isWrD, 1);
    @(negedge clk);
    chk("t1_after_isWrD", isWrD, 0);

    // Same-cycle MEM R1 then ALU R2
    setMem(0, 7'h01, 64'h0000_0000_DEAD_0001);
    setAlu(1, 7'h02, 64'h0123_4567_89AB_CDEF);
    expQ.push_back(ent(0, 7'h01, 64'h0000_0000_DEAD_0001));
    expQ.push_back(ent(1, 7'h02, 64'h0123_4567_89AB_CDEF));
    @(negedge clk); idle();
    chk("t2_stall_cnt2", wbStall, 0);
    repeat (3) @(negedge clk);
    chk("t2_drained_isWrD", isWrD, 0);

    // Fill and overflow: MEM keeps its slot, ALU dropped once full
    for (int k = 0; k < 6; k++) begin
      setMem(1, 7'(7'h10 + k), 64'hF000_0000_0000_0000 | 64'(7'h10 + k));
      setAlu(1, 7'(7'h20 + k), 64'hF000_0000_0000_0000 | 64'(7'h20 + k));
      expQ.push_back(ent(1, 7'(7'h10 + k), 64'hF000_0000_0000_0000 | 64'(7'h10 + k)));
      if (k < 3) expQ.push_back(ent(1, 7'(7'h20 + k), 64'hF000_0000_0000_0000 | 64'(7'h20 + k)));
      @(negedge clk);
      case (k)
        0: chk("t3_stall_cnt2", wbStall, 0);
        1: chk("t3_stall_cnt3", wbStall, 1);
        2: chk("t3_ovf_before", ovfErr, 0);
        3: chk("t3_ovf_set", ovfErr, 1);
        default: chk("t3_stall_full", wbStall, 1);
      endcase
    end
    idle();
    repeat (6) @(negedge clk);
    chk("t3_ovf_sticky", ovfErr, 1);
    chk("t3_drained_isWrD", isWrD, 0);
    chk("t3_drained_stall", wbStall, 0);
    #2 rst_n = 0;
    #1 chk("t3_ovf_rst", ovfErr, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    // qw R5 then younger 32-bit R5: hazards on both views
    setMem(1, 7'h05, 64'h5555_5555_5555_5555);
    setAlu(0, 7'h05, 64'h0000_0000_6666_6666);
    expQ.push_back(ent(1, 7'h05, 64'h5555_5555_5555_5555));
    expQ.push_back(ent(0, 7'h05, 64'h0000_0000_6666_6666));
    @(negedge clk); idle();
    idReg1 = 7'h05; idReg2 = 7'h45; idReg3 = 7'h5F;
    #1;
    chk("t4_haz1", hazard1, 1);
    chk("t4_hit1", fwdHit1, 0);
    chk("t4_haz2", hazard2, 1);
    chk("t4_zzr", {fwdHit3, hazard3}, 0);
    @(negedge clk);
    chk("t4_haz1_outstage", hazard1, 1);
    chk("t4_haz2_outstage", hazard2, 1);
    repeat (2) @(negedge clk);
    chk("t4_clear1", {fwdHit1, hazard1}, 0);
    chk("t4_clear2", {fwdHit2, hazard2}, 0);

    // qw R7 forward, 0x47 hazard, 32-bit 0x45 forward of low word
    setMem(1, 7'h07, 64'hAAAA_BBBB_CCCC_DDDD);
    setAlu(0, 7'h45, 64'h1234_5678_9ABC_DEF0);
    expQ.push_back(ent(1, 7'h07, 64'hAAAA_BBBB_CCCC_DDDD));
    expQ.push_back(ent(0, 7'h45, 64'h1234_5678_9ABC_DEF0));
    @(negedge clk); idle();
    idReg1 = 7'h07; idReg2 = 7'h47; idReg3 = 7'h45;
    #1;
    chk("t5_hit1", fwdHit1, 1);
    chk("t5_data1", fwdData1, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("t5_hit2", fwdHit2, 0);
    chk("t5_haz2", hazard2, 1);
    chk("t5_hit3", fwdHit3, 1);
    chk("t5_data3", fwdData3, 64'h0000_0000_9ABC_DEF0);
    repeat (3) @(negedge clk);

    // Pending qw 0x1F overlaps 0x5F, which must still read 0/0
    setAlu(1, 7'h1F, 64'h0F0F_0F0F_0F0F_0F0F);
    expQ.push_back(ent(1, 7'h1F, 64'h0F0F_0F0F_0F0F_0F0F));
    @(negedge clk); idle();
    idReg1 = 7'h1F; idReg3 = 7'h5F;
    #1;
    chk("t5_hit1f", fwdHit1, 1);
    chk("t5_data1f", fwdData1, 64'h0F0F_0F0F_0F0F_0F0F);
    chk("t5_zzr_hit", fwdHit3, 0);
    chk("t5_zzr_haz", hazard3, 0);
    repeat (3) @(negedge clk);

    // Discarded ids never enqueue
    setMem(1, 7'h5A, 64'h1111_1111_1111_1111);
    setAlu(1, 7'h5F, 64'h2222_2222_2222_2222);
    @(negedge clk); idle();
    for (int i = 0; i < 3; i++) begin
      chk("t6_isWrD", isWrD, 0);
      @(negedge clk);
    end

    // Reset with three pending writes discards them
    setMem(1, 7'h31, 64'h3131_3131_3131_3131);
    setAlu(1, 7'h32, 64'h3232_3232_3232_3232);
    expQ.push_back(ent(1, 7'h31, 64'h3131_3131_3131_3131));
    expQ.push_back(ent(1, 7'h32, 64'h3232_3232_3232_3232));
    @(negedge clk);
    setMem(1, 7'h33, 64'h3333_3333_3333_3333);
    setAlu(1, 7'h34, 64'h3434_3434_3434_3434);
    expQ.push_back(ent(1, 7'h33, 64'h3333_3333_3333_3333));
    expQ.push_back(ent(1, 7'h34, 64'h3434_3434_3434_3434));
    @(negedge clk); idle();
    chk("t7_stall_pending", wbStall, 1);
    #2 rst_n = 0;
    #1;
    chk("t7_rst_isWrD", isWrD, 0);
    chk("t7_rst_stall", wbStall, 0);
    expQ.delete();
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t7_post_isWrD", isWrD, 0);
    end

    chk("leftover_expected", 64'(expQ.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
